id_ex_stage_reg: RTL and testbench

ID/EX pipeline boundary of the RV32IM pipelined core. It captures the decode-stage bundle each cycle and holds it for the execute stage: control fields from the decoder, operands, immediate, PC and register addresses. It detects load-use hazards against the instruction currently in EX and inserts a one-cycle bubble. It also honours execute-stage hold (multi-cycle M-unit busy) and branch/jump flush.

---
 rtl/core_pkg.sv | 45 ++++
 rtl/id_ex_stage_reg_if.sv | 54 +++++
 rtl/id_ex_stage_reg_hazard_detect.sv | 23 ++
 rtl/id_ex_stage_reg.sv | 141 ++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// core_pkg
// Shared definitions for the RV32IM pipeline: base opcodes, the decoder's
// memory access codes (bit 3 flags a real access), writeback select codes
// and the width of the packed ID/EX bundle.
package core_pkg;

    // Base opcodes (inst[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // Memory access codes; bit 3 set means the slot touches memory
    localparam logic [3:0] RW_NONE = 4'b0000;
    localparam logic [3:0] RW_LB   = 4'b1000;
    localparam logic [3:0] RW_LBU  = 4'b1001;
    localparam logic [3:0] RW_LH   = 4'b1010;
    localparam logic [3:0] RW_LHU  = 4'b1011;
    localparam logic [3:0] RW_SB   = 4'b1100;
    localparam logic [3:0] RW_SH   = 4'b1101;
    localparam logic [3:0] RW_SW   = 4'b1110;
    localparam logic [3:0] RW_LW   = 4'b1111;

    // Writeback source select
    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_CSR = 2'b11
    } wb_sel_e;

    // Bundle width: four XLEN values, three register indices, the decoder
    // control fields and the valid bit.
    function automatic int id_ex_width(input int xlen);
        return 4 * xlen + 35;
    endfunction

    localparam int ID_EX_W = id_ex_width(32);

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// id_ex_if
// Groups every decode-side input and execute-side output of the ID/EX
// boundary register. The master side drives the *_i signals (decode stage,
// execute control) and observes the *_o signals; the slave is the register.
interface id_ex_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             valid_i;
    logic [XLEN-1:0]  pc_i, rs1_data_i, rs2_data_i, imm_i;
    logic [4:0]       rs1_addr_i, rs2_addr_i, rd_addr_i;
    logic             op1_sel_i, op2_sel_i;
    logic [4:0]       alu_op_i;
    logic [2:0]       branch_sel_i;
    logic [3:0]       read_write_i;
    logic [1:0]       wb_sel_i;
    logic             reg_w_en_i, is_mem_i, is_load_i;
    logic             ex_busy_i, flush_i;

    logic             valid_o;
    logic [XLEN-1:0]  pc_o, rs1_data_o, rs2_data_o, imm_o;
    logic [4:0]       rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic             op1_sel_o, op2_sel_o;
    logic [4:0]       alu_op_o;
    logic [2:0]       branch_sel_o;
    logic [3:0]       read_write_o;
    logic [1:0]       wb_sel_o;
    logic             reg_w_en_o, is_mem_o, is_load_o;
    logic             front_stall_o;
    logic [CNT_W-1:0] bubble_cnt_o;

    modport master (
        output valid_i, pc_i, rs1_data_i, rs2_data_i, imm_i,
               rs1_addr_i, rs2_addr_i, rd_addr_i, op1_sel_i, op2_sel_i,
               alu_op_i, branch_sel_i, read_write_i, wb_sel_i,
               reg_w_en_i, is_mem_i, is_load_i, ex_busy_i, flush_i,
        input  valid_o, pc_o, rs1_data_o, rs2_data_o, imm_o,
               rs1_addr_o, rs2_addr_o, rd_addr_o, op1_sel_o, op2_sel_o,
               alu_op_o, branch_sel_o, read_write_o, wb_sel_o,
               reg_w_en_o, is_mem_o, is_load_o, front_stall_o, bubble_cnt_o
    );

    modport slave (
        input  valid_i, pc_i, rs1_data_i, rs2_data_i, imm_i,
               rs1_addr_i, rs2_addr_i, rd_addr_i, op1_sel_i, op2_sel_i,
               alu_op_i, branch_sel_i, read_write_i, wb_sel_i,
               reg_w_en_i, is_mem_i, is_load_i, ex_busy_i, flush_i,
        output valid_o, pc_o, rs1_data_o, rs2_data_o, imm_o,
               rs1_addr_o, rs2_addr_o, rd_addr_o, op1_sel_o, op2_sel_o,
               alu_op_o, branch_sel_o, read_write_o, wb_sel_o,
               reg_w_en_o, is_mem_o, is_load_o, front_stall_o, bubble_cnt_o
    );

endinterface

// File: rtl/id_ex_stage_reg_hazard_detect.sv
// id_ex_hazard_detect
// Combinational load-use detector. Flags when the instruction in EX is a
// valid load writing a non-zero register that the valid instruction in ID
// reads through either source index.
//   ex_valid, ex_is_load, ex_rd : instruction currently held for EX
//   id_valid, id_rs1, id_rs2    : instruction currently in decode
//   hz                          : one-cycle bubble required
module id_ex_hazard_detect (
    input  logic       ex_valid,
    input  logic       ex_is_load,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    output logic       hz
);

    // rs2 is compared even for formats that ignore it; a spurious stall is
    // cheaper than decoding the format here.
    assign hz = ex_valid & ex_is_load & id_valid & (ex_rd != 5'd0) &
                ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg
// ID/EX pipeline register. Captures the decode bundle each edge, inserts a
// one-cycle bubble on load-use hazards, holds while EX is busy and squashes
// on a branch/jump flush. Counts inserted load-use bubbles (saturating).
//   clk_i : clock, all state on rising edge
//   rst_i : synchronous active-high reset
//   bus   : id_ex_if slave - decode inputs, ex_busy_i/flush_i, registered
//           outputs, front_stall_o and bubble_cnt_o
module id_ex_stage_reg
    import core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic   clk_i,
    input  logic   rst_i,
    id_ex_if.slave bus
);

    localparam int BUNDLE_W = id_ex_width(XLEN);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic            op1_sel;
        logic            op2_sel;
        logic [4:0]      alu_op;
        logic [2:0]      branch_sel;
        logic [3:0]      read_write;
        logic [1:0]      wb_sel;
        logic            reg_w_en;
        logic            is_mem;
        logic            is_load;
    } bundle_t;

    logic [BUNDLE_W-1:0] state_q;
    bundle_t             cur;
    bundle_t             in_b;
    bundle_t             nxt;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                hz;

    assign cur = state_q;

    id_ex_hazard_detect u_hazard (
        .ex_valid   (cur.valid),
        .ex_is_load (cur.is_load),
        .ex_rd      (cur.rd_addr),
        .id_valid   (bus.valid_i),
        .id_rs1     (bus.rs1_addr_i),
        .id_rs2     (bus.rs2_addr_i),
        .hz         (hz)
    );

    // A flush squashes ID anyway, so a hazard on the squashed instruction
    // must not stall the front end; a busy EX always does.
    assign bus.front_stall_o = bus.ex_busy_i | (hz & ~bus.flush_i);

    // Assemble the decode bundle. An invalid slot keeps its datapath values
    // but has every side-effecting control bit cleared.
    always_comb begin
        in_b            = '0;
        in_b.valid      = bus.valid_i;
        in_b.pc         = bus.pc_i;
        in_b.rs1_data   = bus.rs1_data_i;
        in_b.rs2_data   = bus.rs2_data_i;
        in_b.imm        = bus.imm_i;
        in_b.rs1_addr   = bus.rs1_addr_i;
        in_b.rs2_addr   = bus.rs2_addr_i;
        in_b.rd_addr    = bus.rd_addr_i;
        in_b.op1_sel    = bus.op1_sel_i;
        in_b.op2_sel    = bus.op2_sel_i;
        in_b.alu_op     = bus.alu_op_i;
        in_b.wb_sel     = bus.wb_sel_i;
        if (bus.valid_i) begin
            in_b.branch_sel = bus.branch_sel_i;
            in_b.read_write = bus.read_write_i;
            in_b.reg_w_en   = bus.reg_w_en_i;
            in_b.is_mem     = bus.is_mem_i;
            in_b.is_load    = bus.is_load_i;
        end
    end

    // Next-state priority: flush beats busy (EX drops the held instruction),
    // busy beats the hazard, the hazard beats a normal capture. Only the
    // hazard bubble is counted.
    always_comb begin
        nxt     = cur;
        cnt_nxt = cnt_q;
        if (bus.flush_i) begin
            nxt = '0;
        end else if (bus.ex_busy_i) begin
            nxt = cur;
        end else if (hz) begin
            nxt = '0;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_nxt = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            nxt = in_b;
        end
    end

    // State register with synchronous reset taking precedence over all else.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    assign bus.valid_o      = cur.valid;
    assign bus.pc_o         = cur.pc;
    assign bus.rs1_data_o   = cur.rs1_data;
    assign bus.rs2_data_o   = cur.rs2_data;
    assign bus.imm_o        = cur.imm;
    assign bus.rs1_addr_o   = cur.rs1_addr;
    assign bus.rs2_addr_o   = cur.rs2_addr;
    assign bus.rd_addr_o    = cur.rd_addr;
    assign bus.op1_sel_o    = cur.op1_sel;
    assign bus.op2_sel_o    = cur.op2_sel;
    assign bus.alu_op_o     = cur.alu_op;
    assign bus.branch_sel_o = cur.branch_sel;
    assign bus.read_write_o = cur.read_write;
    assign bus.wb_sel_o     = cur.wb_sel;
    assign bus.reg_w_en_o   = cur.reg_w_en;
    assign bus.is_mem_o     = cur.is_mem;
    assign bus.is_load_o    = cur.is_load;
    assign bus.bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg
// Directed bench for id_ex_stage_reg. Two instances share the same stimulus:
// one with the default 16-bit bubble counter and one with a 2-bit counter to
// reach saturation quickly. Each step drives inputs, checks front_stall_o,
// pushes the expected post-edge state to a scoreboard queue and pops it after
// the edge to compare against the registered outputs.
module tb_id_ex_stage_reg;
    import core_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic        op1_sel;
        logic        op2_sel;
        logic [4:0]  alu_op;
        logic [2:0]  branch_sel;
        logic [3:0]  read_write;
        logic [1:0]  wb_sel;
        logic        reg_w_en;
        logic        is_mem;
        logic        is_load;
    } tb_bundle_t;

    typedef struct {
        tb_bundle_t  st;
        logic [15:0] cnt_a;
        logic [1:0]  cnt_b;
        string       tag;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       busy;
    logic       flush;
    tb_bundle_t drv;
    tb_bundle_t obs;

    tb_bundle_t  m_st;
    logic [15:0] m_cnt_a;
    logic [1:0]  m_cnt_b;
    exp_t        sb[$];

    int tests_run;
    int tests_failed;

    id_ex_if #(.XLEN(32), .CNT_W(16)) bus_a ();
    id_ex_if #(.XLEN(32), .CNT_W(2))  bus_b ();

    id_ex_stage_reg #(.XLEN(32), .CNT_W(16)) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a.slave)
    );

    id_ex_stage_reg #(.XLEN(32), .CNT_W(2)) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Both instances see the same decode bundle and execute controls.
    assign bus_a.valid_i      = drv.valid;
    assign bus_a.pc_i         = drv.pc;
    assign bus_a.rs1_data_i   = drv.rs1_data;
    assign bus_a.rs2_data_i   = drv.rs2_data;
    assign bus_a.imm_i        = drv.imm;
    assign bus_a.rs1_addr_i   = drv.rs1_addr;
    assign bus_a.rs2_addr_i   = drv.rs2_addr;
    assign bus_a.rd_addr_i    = drv.rd_addr;
    assign bus_a.op1_sel_i    = drv.op1_sel;
    assign bus_a.op2_sel_i    = drv.op2_sel;
    assign bus_a.alu_op_i     = drv.alu_op;
    assign bus_a.branch_sel_i = drv.branch_sel;
    assign bus_a.read_write_i = drv.read_write;
    assign bus_a.wb_sel_i     = drv.wb_sel;
    assign bus_a.reg_w_en_i   = drv.reg_w_en;
    assign bus_a.is_mem_i     = drv.is_mem;
    assign bus_a.is_load_i    = drv.is_load;
    assign bus_a.ex_busy_i    = busy;
    assign bus_a.flush_i      = flush;

    assign bus_b.valid_i      = drv.valid;
    assign bus_b.pc_i         = drv.pc;
    assign bus_b.rs1_data_i   = drv.rs1_data;
    assign bus_b.rs2_data_i   = drv.rs2_data;
    assign bus_b.imm_i        = drv.imm;
    assign bus_b.rs1_addr_i   = drv.rs1_addr;
    assign bus_b.rs2_addr_i   = drv.rs2_addr;
    assign bus_b.rd_addr_i    = drv.rd_addr;
    assign bus_b.op1_sel_i    = drv.op1_sel;
    assign bus_b.op2_sel_i    = drv.op2_sel;
    assign bus_b.alu_op_i     = drv.alu_op;
    assign bus_b.branch_sel_i = drv.branch_sel;
    assign bus_b.read_write_i = drv.read_write;
    assign bus_b.wb_sel_i     = drv.wb_sel;
    assign bus_b.reg_w_en_i   = drv.reg_w_en;
    assign bus_b.is_mem_i     = drv.is_mem;
    assign bus_b.is_load_i    = drv.is_load;
    assign bus_b.ex_busy_i    = busy;
    assign bus_b.flush_i      = flush;

    assign obs = {bus_a.valid_o, bus_a.pc_o, bus_a.rs1_data_o, bus_a.rs2_data_o,
                  bus_a.imm_o, bus_a.rs1_addr_o, bus_a.rs2_addr_o, bus_a.rd_addr_o,
                  bus_a.op1_sel_o, bus_a.op2_sel_o, bus_a.alu_op_o,
                  bus_a.branch_sel_o, bus_a.read_write_o, bus_a.wb_sel_o,
                  bus_a.reg_w_en_o, bus_a.is_mem_o, bus_a.is_load_o};

    function automatic tb_bundle_t rand_bundle();
        tb_bundle_t b;
        b.valid      = 1'($urandom());
        b.pc         = $urandom();
        b.rs1_data   = $urandom();
        b.rs2_data   = $urandom();
        b.imm        = $urandom();
        b.rs1_addr   = 5'($urandom());
        b.rs2_addr   = 5'($urandom());
        b.rd_addr    = 5'($urandom());
        b.op1_sel    = 1'($urandom());
        b.op2_sel    = 1'($urandom());
        b.alu_op     = 5'($urandom());
        b.branch_sel = 3'($urandom());
        b.read_write = 4'($urandom());
        b.wb_sel     = 2'($urandom());
        b.reg_w_en   = 1'($urandom());
        b.is_mem     = 1'($urandom());
        b.is_load    = 1'($urandom());
        return b;
    endfunction

    // A valid lw or add with random operand values.
    function automatic tb_bundle_t make_instr(input bit load, input logic [4:0] rs1,
                                              input logic [4:0] rs2, input logic [4:0] rd);
        tb_bundle_t b;
        b            = rand_bundle();
        b.valid      = 1'b1;
        b.rs1_addr   = rs1;
        b.rs2_addr   = rs2;
        b.rd_addr    = rd;
        b.op1_sel    = 1'b0;
        b.op2_sel    = load;
        b.alu_op     = 5'd0;
        b.branch_sel = 3'd0;
        b.read_write = load ? RW_LW : RW_NONE;
        b.wb_sel     = load ? WB_MEM : WB_ALU;
        b.reg_w_en   = 1'b1;
        b.is_mem     = load;
        b.is_load    = load;
        return b;
    endfunction

    function automatic logic model_hz();
        return m_st.valid & m_st.is_load & drv.valid & (m_st.rd_addr != 5'd0) &
               ((m_st.rd_addr == drv.rs1_addr) | (m_st.rd_addr == drv.rs2_addr));
    endfunction

    // Reference behaviour of one rising edge.
    task automatic model_advance();
        logic h;
        h = model_hz();
        if (rst) begin
            m_st    = '0;
            m_cnt_a = '0;
            m_cnt_b = '0;
        end else if (flush) begin
            m_st = '0;
        end else if (busy) begin
            m_st = m_st;
        end else if (h) begin
            m_st = '0;
            if (m_cnt_a != 16'hFFFF) m_cnt_a = m_cnt_a + 16'd1;
            if (m_cnt_b != 2'd3)     m_cnt_b = m_cnt_b + 2'd1;
        end else begin
            m_st = drv;
            if (!drv.valid) begin
                m_st.reg_w_en   = 1'b0;
                m_st.read_write = 4'd0;
                m_st.is_mem     = 1'b0;
                m_st.is_load    = 1'b0;
                m_st.branch_sel = 3'd0;
            end
        end
    endtask

    task automatic check_output();
        exp_t e;
        e = sb.pop_front();
        tests_run++;
        assert (obs === e.st) else begin
            tests_failed++;
            $error("FAIL %s outputs: observed %h expected %h", e.tag, obs, e.st);
        end
        tests_run++;
        assert (bus_a.bubble_cnt_o === e.cnt_a) else begin
            tests_failed++;
            $error("FAIL %s bubble_cnt16: observed %0d expected %0d", e.tag, bus_a.bubble_cnt_o, e.cnt_a);
        end
        tests_run++;
        assert (bus_b.bubble_cnt_o === e.cnt_b) else begin
            tests_failed++;
            $error("FAIL %s bubble_cnt2: observed %0d expected %0d", e.tag, bus_b.bubble_cnt_o, e.cnt_b);
        end
    endtask

    // One clock: check the combinational stall for the driven inputs,
    // queue the expected post-edge state, then compare after the edge.
    task automatic apply_stimulus(input string tag, input bit chk_stall);
        exp_t e;
        logic exp_stall;
        #1;
        if (chk_stall) begin
            exp_stall = busy | (model_hz() & ~flush);
            tests_run++;
            assert (bus_a.front_stall_o === exp_stall) else begin
                tests_failed++;
                $error("FAIL %s front_stall: observed %b expected %b", tag, bus_a.front_stall_o, exp_stall);
            end
        end
        model_advance();
        e.st    = m_st;
        e.cnt_a = m_cnt_a;
        e.cnt_b = m_cnt_b;
        e.tag   = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_output();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        m_st         = '0;
        m_cnt_a      = '0;
        m_cnt_b      = '0;

        // Reset with random decode values
        rst   = 1'b1;
        busy  = 1'b0;
        flush = 1'b0;
        drv   = rand_bundle();
        apply_stimulus("reset0", 1'b0);
        drv = rand_bundle();
        apply_stimulus("reset1", 1'b1);
        rst = 1'b0;

        // Plain capture, then load-use on rs2
        drv = make_instr(1'b0, 5'd1, 5'd2, 5'd3);
        apply_stimulus("add_capture", 1'b1);
        drv = make_instr(1'b1, 5'd2, 5'd0, 5'd5);
        apply_stimulus("lw_capture", 1'b1);
        drv = make_instr(1'b0, 5'd1, 5'd5, 5'd6);
        apply_stimulus("loaduse_bubble", 1'b1);
        apply_stimulus("loaduse_capture", 1'b1);

        // Load to x0 never stalls
        drv = make_instr(1'b1, 5'd3, 5'd0, 5'd0);
        apply_stimulus("lw_x0", 1'b1);
        drv = make_instr(1'b0, 5'd0, 5'd0, 5'd4);
        apply_stimulus("x0_no_hazard", 1'b1);

        // Invalid slot with control bits set
        drv            = make_instr(1'b0, 5'd1, 5'd2, 5'd8);
        drv.valid      = 1'b0;
        drv.is_load    = 1'b1;
        drv.is_mem     = 1'b1;
        drv.read_write = RW_SW;
        drv.branch_sel = 3'b101;
        apply_stimulus("invalid_mask", 1'b1);

        // Divide in EX held by busy for 32 cycles
        drv        = make_instr(1'b0, 5'd10, 5'd11, 5'd7);
        drv.alu_op = 5'd12;
        apply_stimulus("div_capture", 1'b1);
        busy = 1'b1;
        for (int i = 0; i < 32; i++) begin
            drv = rand_bundle();
            apply_stimulus("busy_hold", 1'b1);
        end
        busy = 1'b0;
        drv  = make_instr(1'b0, 5'd7, 5'd1, 5'd12);
        apply_stimulus("after_busy", 1'b1);

        // Flush together with hazard and busy, then flush alone
        drv = make_instr(1'b1, 5'd12, 5'd0, 5'd9);
        apply_stimulus("lw_x9", 1'b1);
        drv   = make_instr(1'b0, 5'd9, 5'd9, 5'd13);
        busy  = 1'b1;
        flush = 1'b1;
        apply_stimulus("flush_hz_busy", 1'b1);
        busy  = 1'b0;
        drv   = make_instr(1'b0, 5'd1, 5'd2, 5'd14);
        apply_stimulus("flush_only", 1'b1);
        flush = 1'b0;

        // Five more load-use bubbles saturate the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            drv = make_instr(1'b1, 5'd1, 5'd2, 5'd5);
            apply_stimulus("sat_lw", 1'b1);
            drv = make_instr(1'b0, 5'd5, 5'd3, 5'd6);
            apply_stimulus("sat_bubble", 1'b1);
        end

        // Reset and flush together mid-operation, with a hazard pending
        drv = make_instr(1'b1, 5'd1, 5'd2, 5'd5);
        apply_stimulus("pre_reset_lw", 1'b1);
        drv   = make_instr(1'b0, 5'd5, 5'd0, 5'd6);
        rst   = 1'b1;
        flush = 1'b1;
        apply_stimulus("reset_flush", 1'b1);
        rst   = 1'b0;
        flush = 1'b0;
        apply_stimulus("post_reset", 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
